imm_encode_loader: RTL

//  Inverse of the core's immediate decode: takes an instruction template plus a 32-bit signed

---
 rtl/imm_encode_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imm_encode_loader.sv
// rtl/imm_encode_loader.sv - encode RV32I immediates into templates and stream them into imem
// Optional IMM_READBACK_CHECK_EN: re-decode each written word and flag mismatches (err 4).
module imm_encode_loader #(
    parameter int ADDR_W     = 8,
    parameter int BASE_WADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_immsrc,
    input  logic [31:0]       in_template,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_WADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
    state_t state, state_next;

    logic              wr_pend, wr_last, last_acc, at_end, rb_err, xfer, start_acc, accept;
    logic [2:0]        chk_err;
    logic [ADDR_W-1:0] addr;
    logic              unused_tmpl;

    assign unused_tmpl = &{1'b0, in_template[31:25]};

    function automatic logic [31:0] encode(input logic [1:0] src, input logic [24:0] t,
                                           input logic [20:0] imm);
        case (src)
            2'b00:   encode = {imm[11:0], t[19:0]};
            2'b01:   encode = {imm[11:5], t[24:12], imm[4:0], t[6:0]};
            2'b10:   encode = {imm[12], imm[10:5], t[24:12], imm[4:1], imm[11], t[6:0]};
            default: encode = {imm[20], imm[10:1], imm[11], imm[19:12], t[11:0]};
        endcase
    endfunction

    // Range beats alignment beats overflow so exactly one code is reported.
    always_comb begin
        chk_err = 3'd0;
        case (in_immsrc)
            2'b00, 2'b01: begin
                if ($signed(in_imm) < -32'sd2048 || $signed(in_imm) > 32'sd2047)
                    chk_err = 3'd1;
            end
            2'b10: begin
                if ($signed(in_imm) < -32'sd4096 || $signed(in_imm) > 32'sd4094)
                    chk_err = 3'd1;
                else if (in_imm[0])
                    chk_err = 3'd2;
            end
            default: begin
                if ($signed(in_imm) < -32'sd1048576 || $signed(in_imm) > 32'sd1048574)
                    chk_err = 3'd1;
                else if (in_imm[0])
                    chk_err = 3'd2;
            end
        endcase
        if (chk_err == 3'd0 && (at_end || (wr_pend && addr == LAST_ADDR)))
            chk_err = 3'd3;
    end

    assign in_ready   = (state == LOAD) && !last_acc && !rb_err;
    assign xfer       = in_valid && in_ready;
    assign accept     = xfer && (chk_err == 3'd0);
    assign start_acc  = start && (state != LOAD);
    assign imem_we    = wr_pend && !rb_err && !reset;
    assign imem_waddr = addr;
    assign busy       = (state == LOAD) || wr_pend;
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if ((xfer && chk_err != 3'd0) || rb_err)
                    state_next = ERROR;
                else if (wr_pend && wr_last)
                    state_next = DONE;
            end
            default: if (start) state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pend    <= 1'b0;
            wr_last    <= 1'b0;
            last_acc   <= 1'b0;
            at_end     <= 1'b0;
            imem_wdata <= 32'd0;
            addr       <= BASE;
            count      <= '0;
            err_code   <= 3'd0;
        end else begin
            wr_pend <= accept;
            if (accept) begin
                imem_wdata <= encode(in_immsrc, in_template[24:0], in_imm[20:0]);
                wr_last    <= in_last;
            end
            if (start_acc) begin
                last_acc <= 1'b0;
                at_end   <= 1'b0;
                addr     <= BASE;
                count    <= '0;
                err_code <= 3'd0;
            end else begin
                if (accept && in_last)
                    last_acc <= 1'b1;
                // The top word is written once; after that the address parks instead of wrapping.
                if (imem_we) begin
                    count <= count + (ADDR_W+1)'(1);
                    if (addr == LAST_ADDR)
                        at_end <= 1'b1;
                    else
                        addr <= addr + ADDR_W'(1);
                end
                if (xfer && chk_err != 3'd0)
                    err_code <= chk_err;
                else if (rb_err)
                    err_code <= 3'd4;
            end
        end
    end

`ifdef IMM_READBACK_CHECK_EN
    logic [31:0] wr_imm;
    logic [1:0]  wr_src;
    logic [31:0] dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_imm <= 32'd0;
            wr_src <= 2'd0;
        end else if (accept) begin
            wr_imm <= in_imm;
            wr_src <= in_immsrc;
        end
    end

    always_comb begin
        case (wr_src)
            2'b00:   dec = {{20{imem_wdata[31]}}, imem_wdata[31:20]};
            2'b01:   dec = {{20{imem_wdata[31]}}, imem_wdata[31:25], imem_wdata[11:7]};
            2'b10:   dec = {{19{imem_wdata[31]}}, imem_wdata[31], imem_wdata[7],
                            imem_wdata[30:25], imem_wdata[11:8], 1'b0};
            default: dec = {{11{imem_wdata[31]}}, imem_wdata[31], imem_wdata[19:12],
                            imem_wdata[20], imem_wdata[30:21], 1'b0};
        endcase
    end

    assign rb_err = wr_pend && (dec != wr_imm);
`else
    assign rb_err = 1'b0;
`endif

endmodule
